rgb_pwm_driver: RTL and testbench



---
 rtl/rgb_pkg.sv | 15 +
 rtl/pwm_channel.sv | 38 +++
 rtl/rgb_pwm_driver.sv | 89 ++++++++
 tb/tb_rgb_pwm_driver.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared widths and colour slice positions for the RGB pipeline
package rgb_pkg;

  localparam int PWM_W = 8;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  localparam logic [PWM_W-1:0] PWM_MAX = 8'hFF;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one colour channel: shadow duty register, compare and registered pin
module pwm_channel
  import rgb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             load,
  input  logic [PWM_W-1:0] duty_in,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  logic [PWM_W-1:0] duty_q, duty_d;
  logic             led_q, led_d;

  // Transparent while idle so a freshly enabled period already holds the current colour.
  always_comb begin
    duty_d = duty_q;
    if (!enable || load) begin
      duty_d = duty_in;
    end
    led_d = enable && (pwm_cnt < duty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rtl/rgb_pwm_driver.sv - three-channel 8-bit PWM LED driver with prescaler and period-aligned duty updates
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] rgb,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        period_start
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             period_start_q, period_start_d;
  logic             tick;
  logic             wrap;

  assign tick = (presc_q == PS_LAST);
  assign wrap = enable && tick && (cnt_q == PWM_MAX);

  // Disabling parks both counters at zero so re-enable always starts a full period.
  always_comb begin
    presc_d        = presc_q;
    cnt_d          = cnt_q;
    period_start_d = wrap;
    if (!enable) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + PWM_W'(1);
    end else begin
      presc_d = presc_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  pwm_channel u_ch_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (wrap),
    .duty_in (rgb[R_MSB:R_LSB]),
    .pwm_cnt (cnt_q),
    .led     (led_r)
  );

  pwm_channel u_ch_g (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (wrap),
    .duty_in (rgb[G_MSB:G_LSB]),
    .pwm_cnt (cnt_q),
    .led     (led_g)
  );

  pwm_channel u_ch_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .load    (wrap),
    .duty_in (rgb[B_MSB:B_LSB]),
    .pwm_cnt (cnt_q),
    .led     (led_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb/tb_rgb_pwm_driver.sv - directed self-checking bench for rgb_pwm_driver (CLK_DIV=1 and CLK_DIV=4)
module tb_rgb_pwm_driver;

  logic        clk;
  logic        rst_n;
  logic        en1, en4;
  logic [23:0] rgb1, rgb4;
  logic        led_r1, led_g1, led_b1, ps1;
  logic        led_r4, led_g4, led_b4, ps4;

  int checks;
  int failures;

  rgb_pwm_driver #(.CLK_DIV(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (en1),
    .rgb          (rgb1),
    .led_r        (led_r1),
    .led_g        (led_g1),
    .led_b        (led_b1),
    .period_start (ps1)
  );

  rgb_pwm_driver #(.CLK_DIV(4)) dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (en4),
    .rgb          (rgb4),
    .led_r        (led_r4),
    .led_g        (led_g4),
    .led_b        (led_b4),
    .period_start (ps4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 256 clocks of dut1 starting just after a period_start sample.
  task automatic window1(output int cr, output int cg, output int cb,
                         output int early_ps, output logic ps_last);
    cr = 0; cg = 0; cb = 0; early_ps = 0; ps_last = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      step();
      cr += int'(led_r1);
      cg += int'(led_g1);
      cb += int'(led_b1);
      if (i < 256) early_ps += int'(ps1);
      else ps_last = ps1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en1 = 1'b0; en4 = 1'b0; rgb1 = '0; rgb4 = '0;
    #2;
    checks++;
    if ({led_r1, led_g1, led_b1, ps1, led_r4, led_g4, led_b4, ps4} !== 8'h00) begin
      failures++;
      $display("FAIL reset_immediate actual=%b expected=00000000",
               {led_r1, led_g1, led_b1, ps1, led_r4, led_g4, led_b4, ps4});
    end
    repeat (5) step();
    checks++;
    if ({led_r1, led_g1, led_b1, ps1, led_r4, led_g4, led_b4, ps4} !== 8'h00) begin
      failures++;
      $display("FAIL reset_held actual=%b expected=00000000",
               {led_r1, led_g1, led_b1, ps1, led_r4, led_g4, led_b4, ps4});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_disabled();
    int hi, pulses;
    hi = 0; pulses = 0;
    rgb1 = 24'hFF8000;
    rgb4 = 24'h004000;
    for (int i = 0; i < 300; i++) begin
      step();
      hi     += int'(led_r1) + int'(led_g1) + int'(led_b1);
      pulses += int'(ps1) + int'(ps4);
    end
    checks++;
    if (hi !== 0) begin
      failures++;
      $display("FAIL disabled_leds actual=%0d expected=0", hi);
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL disabled_period_start actual=%0d expected=0", pulses);
    end
  endtask

  task automatic test_steady();
    int n, cr, cg, cb, early;
    logic pl;
    n = -1;
    en1 = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (ps1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL steady_first_pulse actual=%0d expected=256", n);
    end
    window1(cr, cg, cb, early, pl);
    checks++;
    if (cr !== 255 || cg !== 128 || cb !== 0) begin
      failures++;
      $display("FAIL steady_duty actual=r%0d g%0d b%0d expected=r255 g128 b0", cr, cg, cb);
    end
    checks++;
    if (early !== 0 || pl !== 1'b1) begin
      failures++;
      $display("FAIL steady_period actual=early%0d last%0d expected=early0 last1", early, pl);
    end
  endtask

  task automatic test_mid_update();
    int cr, cg, cb, early;
    logic pl;
    rgb1 = 24'h0000FF;
    window1(cr, cg, cb, early, pl);
    cb = 0; early = 0; pl = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      step();
      cb += int'(led_b1);
      if (i == 50) rgb1 = 24'h000010;
      if (i < 256) early += int'(ps1);
      else pl = ps1;
    end
    checks++;
    if (cb !== 255 || early !== 0 || pl !== 1'b1) begin
      failures++;
      $display("FAIL mid_update_current actual=b%0d early%0d last%0d expected=b255 early0 last1",
               cb, early, pl);
    end
    window1(cr, cg, cb, early, pl);
    checks++;
    if (cb !== 16 || cr !== 0 || cg !== 0 || pl !== 1'b1) begin
      failures++;
      $display("FAIL mid_update_next actual=r%0d g%0d b%0d last%0d expected=r0 g0 b16 last1",
               cr, cg, cb, pl);
    end
  endtask

  task automatic test_enable_drop();
    int cr, cg, cb, early, first;
    logic pl;
    rgb1 = 24'hFFFFFF;
    window1(cr, cg, cb, early, pl);
    repeat (100) step();
    checks++;
    if ({led_r1, led_g1, led_b1} !== 3'b111) begin
      failures++;
      $display("FAIL drop_pre_leds actual=%b expected=111", {led_r1, led_g1, led_b1});
    end
    en1 = 1'b0;
    step();
    checks++;
    if ({led_r1, led_g1, led_b1, ps1} !== 4'b0000) begin
      failures++;
      $display("FAIL drop_next_clock actual=%b expected=0000", {led_r1, led_g1, led_b1, ps1});
    end
    rgb1 = 24'h00FF00;
    repeat (5) step();
    en1 = 1'b1;
    cr = 0; cg = 0; cb = 0; first = -1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i <= 256) begin
        cr += int'(led_r1);
        cg += int'(led_g1);
        cb += int'(led_b1);
      end
      if (ps1) begin
        first = i;
        break;
      end
    end
    checks++;
    if (first !== 256) begin
      failures++;
      $display("FAIL reenable_first_pulse actual=%0d expected=256", first);
    end
    checks++;
    if (cg !== 255 || cr !== 0 || cb !== 0) begin
      failures++;
      $display("FAIL reenable_duty actual=r%0d g%0d b%0d expected=r0 g255 b0", cr, cg, cb);
    end
  endtask

  task automatic test_prescale();
    int first, cg, crb, runs, first_hi, early;
    logic prev, pl;
    en4 = 1'b1;
    first = -1;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (ps4) begin
        first = i;
        break;
      end
    end
    checks++;
    if (first !== 1024) begin
      failures++;
      $display("FAIL prescale_first_pulse actual=%0d expected=1024", first);
    end
    cg = 0; crb = 0; runs = 0; first_hi = -1; early = 0; prev = 1'b0; pl = 1'b0;
    for (int i = 1; i <= 1024; i++) begin
      step();
      cg  += int'(led_g4);
      crb += int'(led_r4) + int'(led_b4);
      if (led_g4 && !prev) runs++;
      if (led_g4 && first_hi < 0) first_hi = i;
      prev = led_g4;
      if (i < 1024) early += int'(ps4);
      else pl = ps4;
    end
    checks++;
    if (cg !== 256 || runs !== 1 || first_hi !== 1) begin
      failures++;
      $display("FAIL prescale_green actual=count%0d runs%0d first%0d expected=count256 runs1 first1",
               cg, runs, first_hi);
    end
    checks++;
    if (crb !== 0) begin
      failures++;
      $display("FAIL prescale_red_blue actual=%0d expected=0", crb);
    end
    checks++;
    if (early !== 0 || pl !== 1'b1) begin
      failures++;
      $display("FAIL prescale_period actual=early%0d last%0d expected=early0 last1", early, pl);
    end
  endtask

  task automatic test_reset_mid();
    int cr, cg, cb, early, first;
    logic pl;
    repeat (10) step();
    checks++;
    if (led_g1 !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre actual=%b expected=1", led_g1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({led_r1, led_g1, led_b1, ps1, led_r4, led_g4, led_b4, ps4} !== 8'h00) begin
      failures++;
      $display("FAIL midreset_immediate actual=%b expected=00000000",
               {led_r1, led_g1, led_b1, ps1, led_r4, led_g4, led_b4, ps4});
    end
    repeat (5) step();
    rst_n = 1'b1;
    cg = 0; first = -1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i <= 256) cg += int'(led_g1);
      if (ps1) begin
        first = i;
        break;
      end
    end
    checks++;
    if (first !== 256 || cg !== 0) begin
      failures++;
      $display("FAIL midreset_restart actual=pulse%0d g%0d expected=pulse256 g0", first, cg);
    end
    window1(cr, cg, cb, early, pl);
    checks++;
    if (cg !== 255 || cr !== 0 || cb !== 0 || pl !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reload actual=r%0d g%0d b%0d last%0d expected=r0 g255 b0 last1",
               cr, cg, cb, pl);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_disabled();
    test_steady();
    test_mid_update();
    test_enable_drop();
    test_prescale();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
